mmio_port_responder: RTL and testbench

// - Memory-mapped I/O responder on the MIPS core's data bus: serves the core's lw/sw to a fixed window,

---
 rtl/mmio_pkg.sv | 56 +++++
 rtl/port_in_sync.sv | 41 ++++
 rtl/mmio_port_responder.sv | 165 ++++++++++++++++
 tb/tb_mmio_port_responder.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// -----------------------------------------------------------------------------
// mmio_pkg
// Shared definitions for the MMIO port responder.
//  - Default window base and PortOut reset value.
//  - Byte offsets of the registers inside the 32-byte window.
//  - A register-select enum derived from those offsets (word index).
//  - STATUS / CTRL bit positions and reset constants.
//  - Helper for write-1-to-clear flag updates.
// Optional feature macro: MMIO_TIMER_EN (used by mmio_port_responder).
// -----------------------------------------------------------------------------
package mmio_pkg;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'hFFFF_0000;
  localparam logic [31:0] OUT_RESET_DEFAULT = 32'h0000_0000;

  // Byte offsets inside the window (bits [1:0] are ignored on access).
  localparam logic [4:0] OFF_PORT_OUT = 5'h00;
  localparam logic [4:0] OFF_PORT_IN  = 5'h04;
  localparam logic [4:0] OFF_STATUS   = 5'h08;
  localparam logic [4:0] OFF_CTRL     = 5'h0C;
  localparam logic [4:0] OFF_TMR_CMP  = 5'h10;
  localparam logic [4:0] OFF_TMR_CNT  = 5'h14;

  typedef enum logic [2:0] {
    SEL_PORT_OUT = OFF_PORT_OUT[4:2],
    SEL_PORT_IN  = OFF_PORT_IN[4:2],
    SEL_STATUS   = OFF_STATUS[4:2],
    SEL_CTRL     = OFF_CTRL[4:2],
    SEL_TMR_CMP  = OFF_TMR_CMP[4:2],
    SEL_TMR_CNT  = OFF_TMR_CNT[4:2]
  } reg_sel_e;

  localparam int STATUS_W = 2;
  localparam int CTRL_W   = 3;

  localparam int STAT_IN_CHG  = 0;
  localparam int STAT_TMR_HIT = 1;
  localparam int CTRL_TMR_ON  = 0;
  localparam int CTRL_IE_IN   = 1;
  localparam int CTRL_IE_TMR  = 2;

  localparam logic [STATUS_W-1:0] STATUS_RESET  = '0;
  localparam logic [CTRL_W-1:0]   CTRL_RESET    = '0;
  localparam logic [31:0]         TMR_CMP_RESET = 32'hFFFF_FFFF;
  localparam logic [31:0]         TMR_CNT_RESET = 32'h0000_0000;

  // A set event wins over a simultaneous clear, so no event is ever lost.
  function automatic logic [STATUS_W-1:0] w1c_update(
    input logic [STATUS_W-1:0] cur,
    input logic [STATUS_W-1:0] clr,
    input logic [STATUS_W-1:0] set
  );
    return (cur & ~clr) | set;
  endfunction

endpackage

// File: rtl/port_in_sync.sv
// -----------------------------------------------------------------------------
// port_in_sync
// Two-flop synchronizer for the asynchronous PortIn bus plus a third flop
// used to detect a change of the synchronized value.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset (all flops to 0)
//   i_async    in   WIDTH  raw external input
//   o_sync     out  WIDTH  second synchronizer stage (safe to use)
//   o_changed  out  1      second stage differs from the third stage
// -----------------------------------------------------------------------------
module port_in_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync,
  output logic             o_changed
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;
  logic [WIDTH-1:0] r_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= '0;
      r_sync <= '0;
      r_last <= '0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_last <= r_sync;
    end
  end

  assign o_sync    = r_sync;
  assign o_changed = (r_sync != r_last);

endmodule

// File: rtl/mmio_port_responder.sv
// -----------------------------------------------------------------------------
// mmio_port_responder
// MMIO responder on the MIPS data bus: a 32-byte register window holding the
// PortOut register, the synchronized PortIn value, sticky W1C event flags,
// control bits, an optional timer and a registered interrupt line.
// Build option: define MMIO_TIMER_EN to include the timer (TMR_CMP/TMR_CNT,
// CTRL TMR_ON/IE_TMR, STATUS TMR_HIT). Without it those read as 0.
// Ports:
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous active-high reset
//   Address    in   32  byte address
//   WriteData  in   32  store data
//   MemWrite   in   1   store strobe
//   MemRead    in   1   load strobe
//   Hit        out  1   Address inside [BASE_ADDR, BASE_ADDR+0x1F]
//   ReadData   out  32  combinational load data (0 unless Hit & MemRead)
//   PortIn     in   8   asynchronous external input
//   PortOut    out  32  output register
//   Irq        out  1   registered level interrupt
// -----------------------------------------------------------------------------
module mmio_port_responder
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT,
  parameter logic [31:0] OUT_RESET = OUT_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic        Hit,
  output logic [31:0] ReadData,
  input  logic [7:0]  PortIn,
  output logic [31:0] PortOut,
  output logic        Irq
);

  logic [31:0]         w_offset;
  reg_sel_e            w_sel;
  logic                w_unused_offset;
  logic                w_wr;
  logic                w_wr_out;
  logic                w_wr_status;
  logic                w_wr_ctrl;
  logic [7:0]          w_sync;
  logic                w_in_changed;
  logic [STATUS_W-1:0] w_status_set;
  logic [STATUS_W-1:0] w_status_clr;
  logic [STATUS_W-1:0] w_status_next;
  logic                w_irq_next;
  logic [31:0]         w_rdata;

  logic [31:0]         r_port_out;
  logic [STATUS_W-1:0] r_status;
  logic [CTRL_W-1:0]   r_ctrl;
  logic                r_irq;

  // Window decode: Hit compares the upper address bits, the register is
  // picked from the word index of the base-relative offset.
  assign w_offset        = Address - BASE_ADDR;
  assign w_sel           = reg_sel_e'(w_offset[4:2]);
  assign w_unused_offset = ^{w_offset[31:5], w_offset[1:0]};
  assign Hit             = (Address[31:5] == BASE_ADDR[31:5]);

  assign w_wr        = Hit & MemWrite;
  assign w_wr_out    = w_wr && (w_sel == SEL_PORT_OUT);
  assign w_wr_status = w_wr && (w_sel == SEL_STATUS);
  assign w_wr_ctrl   = w_wr && (w_sel == SEL_CTRL);

  port_in_sync #(.WIDTH(8)) u_port_in_sync (
    .clk       (clk),
    .reset     (reset),
    .i_async   (PortIn),
    .o_sync    (w_sync),
    .o_changed (w_in_changed)
  );

`ifdef MMIO_TIMER_EN
  localparam logic [CTRL_W-1:0] CTRL_WR_MASK = 3'b111;

  logic [31:0] r_tmr_cmp;
  logic [31:0] r_tmr_cnt;
  logic        w_wr_cmp;
  logic        w_tmr_hit;

  assign w_wr_cmp  = w_wr && (w_sel == SEL_TMR_CMP);
  assign w_tmr_hit = r_ctrl[CTRL_TMR_ON] && (r_tmr_cnt == r_tmr_cmp);

  // Count wraps to 0 on the compare match, giving a period of TMR_CMP+1.
  // A compare write restarts the period from 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmr_cmp <= TMR_CMP_RESET;
      r_tmr_cnt <= TMR_CNT_RESET;
    end else begin
      if (w_wr_cmp) begin
        r_tmr_cmp <= WriteData;
        r_tmr_cnt <= '0;
      end else if (w_tmr_hit) begin
        r_tmr_cnt <= '0;
      end else if (r_ctrl[CTRL_TMR_ON]) begin
        r_tmr_cnt <= r_tmr_cnt + 32'd1;
      end
    end
  end
`else
  // Only IE_IN is implemented; timer control bits stay 0.
  localparam logic [CTRL_W-1:0] CTRL_WR_MASK = 3'b010;
`endif

  always_comb begin
    w_status_set = '0;
    w_status_set[STAT_IN_CHG] = w_in_changed;
`ifdef MMIO_TIMER_EN
    w_status_set[STAT_TMR_HIT] = w_tmr_hit;
`endif
    w_status_clr  = w_wr_status ? WriteData[STATUS_W-1:0] : '0;
    w_status_next = w1c_update(r_status, w_status_clr, w_status_set);
  end

  // Timer flag and enable are held at 0 without the timer, so this reduces
  // to IN_CHG & IE_IN in that build.
  assign w_irq_next = (r_status[STAT_IN_CHG]  & r_ctrl[CTRL_IE_IN]) |
                      (r_status[STAT_TMR_HIT] & r_ctrl[CTRL_IE_TMR]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_port_out <= OUT_RESET;
      r_status   <= STATUS_RESET;
      r_ctrl     <= CTRL_RESET;
      r_irq      <= 1'b0;
    end else begin
      if (w_wr_out) begin
        r_port_out <= WriteData;
      end
      if (w_wr_ctrl) begin
        r_ctrl <= WriteData[CTRL_W-1:0] & CTRL_WR_MASK;
      end
      r_status <= w_status_next;
      r_irq    <= w_irq_next;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_sel)
      SEL_PORT_OUT: w_rdata = r_port_out;
      SEL_PORT_IN:  w_rdata = {24'b0, w_sync};
      SEL_STATUS:   w_rdata = {{(32-STATUS_W){1'b0}}, r_status};
      SEL_CTRL:     w_rdata = {{(32-CTRL_W){1'b0}}, r_ctrl};
`ifdef MMIO_TIMER_EN
      SEL_TMR_CMP:  w_rdata = r_tmr_cmp;
      SEL_TMR_CNT:  w_rdata = r_tmr_cnt;
`endif
      default:      w_rdata = '0;
    endcase
    ReadData = (Hit && MemRead) ? w_rdata : '0;
  end

  assign PortOut = r_port_out;
  assign Irq     = r_irq;

endmodule

// File: tb/tb_mmio_port_responder.sv
// -----------------------------------------------------------------------------
// tb_mmio_port_responder
// Self-checking bench: fixed vector table, hand-written multi-cycle sequences
// (PortIn change, W1C collision, IRQ, timer, reset) and random bus traffic,
// all compared against a bus-level reference model of the register window.
// -----------------------------------------------------------------------------
module tb_mmio_port_responder;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
`ifdef MMIO_TIMER_EN
  localparam bit          TMR       = 1'b1;
  localparam logic [31:0] EXP_CTRL7 = 32'd7;
  localparam logic [31:0] EXP_CMP_R = 32'hFFFF_FFFF;
  localparam logic [31:0] EXP_CNT2  = 32'd2;
`else
  localparam bit          TMR       = 1'b0;
  localparam logic [31:0] EXP_CTRL7 = 32'd2;
  localparam logic [31:0] EXP_CMP_R = 32'd0;
  localparam logic [31:0] EXP_CNT2  = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic        Hit;
  logic [31:0] ReadData;
  logic [7:0]  PortIn;
  logic [31:0] PortOut;
  logic        Irq;

  always #5 clk = ~clk;

  mmio_port_responder dut (
    .clk       (clk),
    .reset     (reset),
    .Address   (Address),
    .WriteData (WriteData),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .Hit       (Hit),
    .ReadData  (ReadData),
    .PortIn    (PortIn),
    .PortOut   (PortOut),
    .Irq       (Irq)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  // ---------------- reference model ----------------
  logic [31:0] m_out, m_cmp, m_cnt;
  logic [1:0]  m_status;
  logic [2:0]  m_ctrl;
  logic        m_irq;
  logic [7:0]  m_pin_hist [3];  // PortIn sampled at the last, 2nd-last, 3rd-last edges

  function automatic logic m_hit(input logic [31:0] a);
    return (a >= BASE) && (a <= BASE + 32'd31);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] word;
    if (!m_hit(a)) return 32'd0;
    word = (a - BASE) >> 2;
    case (word)
      32'd0:   return m_out;
      32'd1:   return {24'd0, m_pin_hist[1]};
      32'd2:   return {30'd0, m_status};
      32'd3:   return {29'd0, m_ctrl};
      32'd4:   return TMR ? m_cmp : 32'd0;
      32'd5:   return TMR ? m_cnt : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_out = 32'd0; m_cmp = 32'hFFFF_FFFF; m_cnt = 32'd0;
    m_status = 2'b00; m_ctrl = 3'b000; m_irq = 1'b0;
    for (int k = 0; k < 3; k++) m_pin_hist[k] = 8'h00;
  endtask

  // State after the coming clock edge, from the inputs currently on the bus.
  task automatic model_edge();
    logic [31:0] word, cnt_n;
    logic        wr, in_chg, tmr_hit, irq_n;
    logic [1:0]  clr;
    word    = (Address - BASE) >> 2;
    wr      = MemWrite && m_hit(Address);
    in_chg  = (m_pin_hist[1] != m_pin_hist[2]);
    tmr_hit = TMR && m_ctrl[0] && (m_cnt == m_cmp);
    irq_n   = (m_status[0] && m_ctrl[1]) || (m_status[1] && m_ctrl[2]);
    clr     = (wr && word == 32'd2) ? WriteData[1:0] : 2'b00;
    if (TMR && wr && word == 32'd4) cnt_n = 32'd0;
    else if (tmr_hit)               cnt_n = 32'd0;
    else if (TMR && m_ctrl[0])      cnt_n = m_cnt + 32'd1;
    else                            cnt_n = m_cnt;
    if (wr && word == 32'd0) m_out = WriteData;
    if (wr && word == 32'd3) m_ctrl = WriteData[2:0] & (TMR ? 3'b111 : 3'b010);
    if (TMR && wr && word == 32'd4) m_cmp = WriteData;
    m_cnt    = cnt_n;
    m_status = (m_status & ~clr) | {tmr_hit, in_chg};
    m_irq    = irq_n;
    m_pin_hist[2] = m_pin_hist[1];
    m_pin_hist[1] = m_pin_hist[0];
    m_pin_hist[0] = PortIn;
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic [31:0] a, input logic [31:0] wd, input logic we,
                       input logic re, input logic [7:0] pin);
    Address = a; WriteData = wd; MemWrite = we; MemRead = re; PortIn = pin;
    #1;
  endtask

  task automatic check_model();
    check("hit", {31'd0, Hit}, {31'd0, m_hit(Address)});
    check("rdata", ReadData, MemRead ? m_read(Address) : 32'd0);
    check("portout", PortOut, m_out);
    check("irq", {31'd0, Irq}, {31'd0, m_irq});
  endtask

  task automatic finish_cycle();
    n_txn++;
    $display("txn %0d addr=%h we=%0d re=%0d wd=%h pin=%h hit=%0d rd=%h out=%h irq=%0d",
             n_txn, Address, MemWrite, MemRead, WriteData, PortIn, Hit, ReadData, PortOut, Irq);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input logic [31:0] a, input logic [31:0] wd, input logic we,
                       input logic re, input logic [7:0] pin);
    apply(a, wd, we, re, pin);
    check_model();
    finish_cycle();
  endtask

  task automatic read_const(input string name, input logic [31:0] a,
                            input logic [7:0] pin, input logic [31:0] exp);
    apply(a, 32'd0, 1'b0, 1'b1, pin);
    check(name, ReadData, exp);
    check_model();
    finish_cycle();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic        exp_hit;
    logic [31:0] exp_rd;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];
  logic [7:0] pin;

  initial begin
    vecs[0]  = '{32'hFFFF_0000, 32'hA5A5_0F0F, 1'b1, 1'b0, 1'b1, 32'd0};
    vecs[1]  = '{32'hFFFF_0000, 32'd0,        1'b0, 1'b1, 1'b1, 32'hA5A5_0F0F};
    vecs[2]  = '{32'hFFFF_0020, 32'd0,        1'b0, 1'b1, 1'b0, 32'd0};
    vecs[3]  = '{32'hFFFF_0003, 32'd0,        1'b0, 1'b1, 1'b1, 32'hA5A5_0F0F};
    vecs[4]  = '{32'hFFFE_FFFC, 32'd0,        1'b0, 1'b1, 1'b0, 32'd0};
    vecs[5]  = '{32'hFFFF_001C, 32'd0,        1'b0, 1'b1, 1'b1, 32'd0};
    vecs[6]  = '{32'hFFFF_0004, 32'h1234_5678, 1'b1, 1'b0, 1'b1, 32'd0};
    vecs[7]  = '{32'hFFFF_0004, 32'd0,        1'b0, 1'b1, 1'b1, 32'd0};
    vecs[8]  = '{32'hFFFF_000C, 32'd7,        1'b1, 1'b0, 1'b1, 32'd0};
    vecs[9]  = '{32'hFFFF_000C, 32'd0,        1'b0, 1'b1, 1'b1, EXP_CTRL7};
    vecs[10] = '{32'hFFFF_000C, 32'd0,        1'b1, 1'b0, 1'b1, 32'd0};
    vecs[11] = '{32'hFFFF_0010, 32'd0,        1'b0, 1'b1, 1'b1, EXP_CMP_R};
    vecs[12] = '{32'hFFFF_0000, 32'd0,        1'b0, 1'b0, 1'b1, 32'd0};
    vecs[13] = '{32'hFFFF_0020, 32'd0,        1'b1, 1'b0, 1'b0, 32'd0};
    vecs[14] = '{32'hFFFF_0000, 32'd0,        1'b0, 1'b1, 1'b1, 32'hA5A5_0F0F};
    vecs[15] = '{32'hFFFF_0014, 32'd0,        1'b0, 1'b1, 1'b1, EXP_CNT2};

    pin = 8'h00;
    reset = 1'b1;
    apply(32'd0, 32'd0, 1'b0, 1'b0, pin);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;

    // Reset state
    check("rst_portout", PortOut, 32'd0);
    check("rst_irq", {31'd0, Irq}, 32'd0);
    read_const("rst_status", BASE + 32'h08, pin, 32'd0);
    read_const("rst_ctrl",   BASE + 32'h0C, pin, 32'd0);
    read_const("rst_cmp",    BASE + 32'h10, pin, EXP_CMP_R);
    read_const("rst_cnt",    BASE + 32'h14, pin, 32'd0);

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      apply(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].re, pin);
      check($sformatf("vec%0d_hit", i), {31'd0, Hit}, {31'd0, vecs[i].exp_hit});
      check($sformatf("vec%0d_rd", i), ReadData, vecs[i].exp_rd);
      check_model();
      finish_cycle();
    end
    check("sw_outside_ignored", PortOut, 32'hA5A5_0F0F);

    // PortIn 00 -> 3C: visible after two edges, IN_CHG one edge later, W1C clears
    pin = 8'h3C;
    cycle(BASE, 32'd0, 1'b0, 1'b0, pin);
    cycle(BASE, 32'd0, 1'b0, 1'b0, pin);
    read_const("port_in_3c", BASE + 32'h04, pin, 32'h0000_003C);
    read_const("in_chg_set", BASE + 32'h08, pin, 32'd1);
    cycle(BASE + 32'h08, 32'd1, 1'b1, 1'b0, pin);
    read_const("in_chg_w1c", BASE + 32'h08, pin, 32'd0);

    // IN_CHG event coincides with a W1C of bit0: flag must survive
    pin = 8'h00;
    cycle(BASE, 32'd0, 1'b0, 1'b0, pin);
    cycle(BASE, 32'd0, 1'b0, 1'b0, pin);
    cycle(BASE + 32'h08, 32'd1, 1'b1, 1'b0, pin);
    read_const("set_beats_clear", BASE + 32'h08, pin, 32'd1);

    // IE_IN with a pending flag -> Irq one cycle after the enable lands
    cycle(BASE + 32'h0C, 32'd2, 1'b1, 1'b0, pin);
    apply(BASE, 32'd0, 1'b0, 1'b0, pin);
    check("irq_lag", {31'd0, Irq}, 32'd0);
    finish_cycle();
    apply(BASE + 32'h08, 32'd1, 1'b1, 1'b0, pin);
    check("irq_in_chg", {31'd0, Irq}, 32'd1);
    check_model();
    finish_cycle();
    apply(BASE, 32'd0, 1'b0, 1'b0, pin);
    check("irq_hold", {31'd0, Irq}, 32'd1);
    finish_cycle();
    apply(BASE, 32'd0, 1'b0, 1'b0, pin);
    check("irq_drop", {31'd0, Irq}, 32'd0);
    finish_cycle();

`ifdef MMIO_TIMER_EN
    // TMR_CMP=4, CTRL=TMR_ON|IE_TMR: count 0..4, wrap, TMR_HIT, Irq next cycle
    cycle(BASE + 32'h10, 32'd4, 1'b1, 1'b0, pin);
    cycle(BASE + 32'h0C, 32'd5, 1'b1, 1'b0, pin);
    for (int k = 0; k < 5; k++)
      read_const($sformatf("tmr_cnt%0d", k), BASE + 32'h14, pin, k);
    apply(BASE + 32'h14, 32'd0, 1'b0, 1'b1, pin);
    check("tmr_wrap", ReadData, 32'd0);
    check("tmr_irq_lag", {31'd0, Irq}, 32'd0);
    finish_cycle();
    apply(BASE + 32'h08, 32'd0, 1'b0, 1'b1, pin);
    check("tmr_hit_flag", ReadData, 32'd2);
    check("tmr_irq", {31'd0, Irq}, 32'd1);
    finish_cycle();
    cycle(BASE + 32'h08, 32'd2, 1'b1, 1'b0, pin);
    apply(BASE, 32'd0, 1'b0, 1'b0, pin);
    check("tmr_irq_hold", {31'd0, Irq}, 32'd1);
    finish_cycle();
    apply(BASE + 32'h0C, 32'd0, 1'b1, 1'b0, pin);
    check("tmr_irq_drop", {31'd0, Irq}, 32'd0);
    finish_cycle();
    // TMR_CMP=0: hit every cycle, count pinned at 0
    cycle(BASE + 32'h10, 32'd0, 1'b1, 1'b0, pin);
    cycle(BASE + 32'h0C, 32'd1, 1'b1, 1'b0, pin);
    repeat (3) read_const("tmr_cmp0_cnt", BASE + 32'h14, pin, 32'd0);
    cycle(BASE + 32'h0C, 32'd0, 1'b1, 1'b0, pin);
`else
    // No timer: writes to CMP/CTRL timer bits ignored, Irq only from IN_CHG
    cycle(BASE + 32'h10, 32'd3, 1'b1, 1'b0, pin);
    cycle(BASE + 32'h0C, 32'd5, 1'b1, 1'b0, pin);
    repeat (6) cycle(BASE, 32'd0, 1'b0, 1'b0, pin);
    read_const("notmr_cmp", BASE + 32'h10, pin, 32'd0);
    read_const("notmr_cnt", BASE + 32'h14, pin, 32'd0);
    read_const("notmr_status", BASE + 32'h08, pin, 32'd0);
    apply(BASE, 32'd0, 1'b0, 1'b0, pin);
    check("notmr_irq", {31'd0, Irq}, 32'd0);
    finish_cycle();
`endif

    // Random bus traffic against the model
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, wd;
      logic        we, re;
      a  = ($urandom_range(0, 9) == 0) ? $urandom : BASE - 32'd4 + $urandom_range(0, 43);
      wd = $urandom;
      if (((a - BASE) >> 2) == 32'd4) wd = $urandom_range(0, 6);
      we = ($urandom_range(0, 2) == 0);
      re = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 7) == 0) pin = 8'($urandom);
      cycle(a, wd, we, re, pin);
    end

    // Reset mid-sequence
    cycle(BASE, 32'hDEAD_BEEF, 1'b1, 1'b0, pin);
    cycle(BASE + 32'h0C, 32'd7, 1'b1, 1'b0, pin);
    apply(BASE + 32'h08, 32'd0, 1'b0, 1'b1, pin);
    reset = 1'b1;
    #1;
    model_reset();
    check("midrst_portout", PortOut, 32'd0);
    check("midrst_irq", {31'd0, Irq}, 32'd0);
    check("midrst_status", ReadData, 32'd0);
    apply(BASE + 32'h0C, 32'd0, 1'b0, 1'b1, pin);
    check("midrst_ctrl", ReadData, 32'd0);
    apply(BASE + 32'h10, 32'd0, 1'b0, 1'b1, pin);
    check("midrst_cmp", ReadData, EXP_CMP_R);
    apply(BASE + 32'h14, 32'd0, 1'b0, 1'b1, pin);
    check("midrst_cnt", ReadData, 32'd0);
    apply(BASE, 32'h1234_5678, 1'b1, 1'b0, pin);
    @(posedge clk);
    #1;
    check("rst_blocks_store", PortOut, 32'd0);
    reset = 1'b0;
    apply(BASE, 32'd0, 1'b0, 1'b0, pin);
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 3) == 0) pin = 8'($urandom);
      cycle(BASE + $urandom_range(0, 31), $urandom_range(0, 7), $urandom_range(0, 1) == 1,
            1'b1, pin);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
